fc_layer_engine: RTL and testbench

Layer-side responder to the pipeline controller's layer_start/layer_busy/layer_done handshake. It implements one fully connected layer in the multi-layer network. On an accepted start it pops INPUT_SIZE activations from the upstream FIFO into a local buffer and computes OUTPUT_SIZE neurons on one signed fixed-point MAC, reading weights from an external synchronous memory. Each neuron result is saturated, optionally passed through ReLU, and pushed to the downstream FIFO.

---
 rtl/fc_layer_engine.sv | 177 +++++++++++++++++
 tb/tb_fc_layer_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_engine.sv
// One fully connected layer: buffers INPUT_SIZE activations, then runs OUTPUT_SIZE
// neurons through a single signed MAC fed by a synchronous weight memory.
module fc_layer_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = 4,
  parameter int ACC_WIDTH   = 40,
  parameter int RELU_EN     = 1,
  parameter int ADDR_WIDTH  = $clog2(INPUT_SIZE*OUTPUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_start,
  output logic                  layer_busy,
  output logic                  layer_done,
  input  logic                  in_fifo_empty,
  output logic                  in_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] in_fifo_data,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_data,
  input  logic                  out_fifo_full,
  output logic                  out_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] out_fifo_data
);

  localparam int IDX_W  = $clog2(INPUT_SIZE);
  localparam int J_W    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(INPUT_SIZE - 1);
  localparam logic [J_W-1:0]   LAST_J = J_W'(OUTPUT_SIZE - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_FLUSH, S_WRITE, S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_rd_en;
  logic                          w_wr_en;

  logic [IDX_W-1:0]              r_i;
  logic [J_W-1:0]                r_j;
  logic signed [DATA_WIDTH-1:0]  r_buf [INPUT_SIZE];

  logic [IDX_W-1:0]              r_idx_p0;
  logic                          r_vld_p0;
  logic signed [PROD_W-1:0]      w_prod_p1;
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt_p1;
  logic signed [ACC_WIDTH-1:0]   r_acc_p1;
  logic signed [DATA_WIDTH-1:0]  r_res_p2;

  // Drop the fraction (floor via arithmetic shift) and clamp to the data range.
  function automatic logic signed [DATA_WIDTH-1:0] f_scale_sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] f_relu(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if ((RELU_EN != 0) && v[DATA_WIDTH-1]) return '0;
    else                                   return v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (layer_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_rd_en = !in_fifo_empty;
        if (w_rd_en && (r_i == LAST_I)) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_i == LAST_I) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_wr_en = !out_fifo_full;
        if (w_wr_en) w_state_nxt = (r_j == LAST_J) ? S_DONE : S_COMPUTE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage p0: address issue; p1: product of returned weight and buffered activation
  assign weight_addr  = ADDR_WIDTH'(int'(r_j) * INPUT_SIZE + int'(r_i));
  assign w_prod_p1    = $signed(weight_data) * r_buf[r_idx_p0];
  assign w_acc_nxt_p1 = r_acc_p1 +
                        {{(ACC_WIDTH-PROD_W){w_prod_p1[PROD_W-1]}}, w_prod_p1};

  always_ff @(posedge clk) begin
    if (w_rd_en) r_buf[r_i] <= in_fifo_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_idx_p0 <= '0;
      r_vld_p0 <= 1'b0;
      r_acc_p1 <= '0;
      r_res_p2 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx_p0 <= r_i;
      r_vld_p0 <= (r_state == S_COMPUTE);
      case (r_state)
        S_IDLE: begin
          if (layer_start) begin
            r_i <= '0;
            r_j <= '0;
          end
        end
        S_LOAD: begin
          if (w_rd_en) begin
            if (r_i == LAST_I) begin
              r_i      <= '0;
              r_acc_p1 <= '0;
            end else begin
              r_i <= r_i + IDX_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          // The first cycle of a neuron has no weight returned yet.
          if (r_vld_p0) r_acc_p1 <= w_acc_nxt_p1;
          r_i <= (r_i == LAST_I) ? '0 : r_i + IDX_W'(1);
        end
        S_FLUSH: begin
          // Stage p2: final product folded in, result scaled and held for the push
          r_acc_p1 <= w_acc_nxt_p1;
          r_res_p2 <= f_relu(f_scale_sat(w_acc_nxt_p1));
        end
        S_WRITE: begin
          if (w_wr_en && (r_j != LAST_J)) begin
            r_j      <= r_j + J_W'(1);
            r_i      <= '0;
            r_acc_p1 <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign layer_busy     = (r_state != S_IDLE);
  assign layer_done     = (r_state == S_DONE);
  assign in_fifo_rd_en  = w_rd_en;
  assign out_fifo_wr_en = w_wr_en;
  assign out_fifo_data  = r_res_p2;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: two instances (ReLU on / off) share FIFO and
// weight-memory stimulus; results are compared against hand-computed values.
module tb_fc_layer_engine;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int M  = 2;
  localparam int AW = 3;
  localparam int NV = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, empty, full;
  logic busyA, doneA, rdA, wrA, busyB, doneB, rdB, wrB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] xdA, xdB, odA, odB;
  logic [DW-1:0] wdA = '0;
  logic [DW-1:0] wdB = '0;

  logic signed [DW-1:0] x_mem [N];
  logic signed [DW-1:0] w_mem [N*M];
  logic signed [DW-1:0] qA[$];
  logic signed [DW-1:0] qB[$];
  int ptrA = 0;
  int ptrB = 0;
  int cyc  = 0;

  fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .INPUT_SIZE(N), .OUTPUT_SIZE(M),
                    .ACC_WIDTH(40), .RELU_EN(1), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst(rst), .layer_start(start), .layer_busy(busyA), .layer_done(doneA),
    .in_fifo_empty(empty), .in_fifo_rd_en(rdA), .in_fifo_data(xdA),
    .weight_addr(addrA), .weight_data(wdA),
    .out_fifo_full(full), .out_fifo_wr_en(wrA), .out_fifo_data(odA));

  fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .INPUT_SIZE(N), .OUTPUT_SIZE(M),
                    .ACC_WIDTH(40), .RELU_EN(0), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .rst(rst), .layer_start(start), .layer_busy(busyB), .layer_done(doneB),
    .in_fifo_empty(empty), .in_fifo_rd_en(rdB), .in_fifo_data(xdB),
    .weight_addr(addrB), .weight_data(wdB),
    .out_fifo_full(full), .out_fifo_wr_en(wrB), .out_fifo_data(odB));

  assign xdA = x_mem[ptrA % N];
  assign xdB = x_mem[ptrB % N];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wdA <= w_mem[addrA];
    wdB <= w_mem[addrB];
    if (rdA) ptrA <= ptrA + 1;
    if (rdB) ptrB <= ptrB + 1;
    if (wrA) qA.push_back(odA);
    if (wrB) qB.push_back(odB);
  end

  typedef struct {
    logic [N-1:0][DW-1:0]   x;
    logic [N*M-1:0][DW-1:0] w;
    int eA [M];
    int eB [M];
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mk(input int k, input int x0, input int x1, input int x2, input int x3,
                    input int w0, input int w1, input int w2, input int w3,
                    input int w4, input int w5, input int w6, input int w7,
                    input int a0, input int a1, input int b0, input int b1);
    vecs[k].x[0] = 16'(x0); vecs[k].x[1] = 16'(x1);
    vecs[k].x[2] = 16'(x2); vecs[k].x[3] = 16'(x3);
    vecs[k].w[0] = 16'(w0); vecs[k].w[1] = 16'(w1);
    vecs[k].w[2] = 16'(w2); vecs[k].w[3] = 16'(w3);
    vecs[k].w[4] = 16'(w4); vecs[k].w[5] = 16'(w5);
    vecs[k].w[6] = 16'(w6); vecs[k].w[7] = 16'(w7);
    vecs[k].eA[0] = a0; vecs[k].eA[1] = a1;
    vecs[k].eB[0] = b0; vecs[k].eB[1] = b1;
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < N; i++)   x_mem[i] = vecs[k].x[i];
    for (int i = 0; i < N*M; i++) w_mem[i] = vecs[k].w[i];
  endtask

  // Start one inference and wait (bounded) for layer_done; lat is cycles start->done.
  task automatic run_inf(output int lat);
    int c0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (doneA) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_results(input string tag, input int k, input int nA, input int nB);
    chk({tag, " pushesA"}, qA.size() - nA, M);
    chk({tag, " pushesB"}, qB.size() - nB, M);
    if (qA.size() >= nA + M && qB.size() >= nB + M) begin
      for (int j = 0; j < M; j++) begin
        chk($sformatf("%s reluA n%0d", tag, j), int'(qA[nA+j]), vecs[k].eA[j]);
        chk($sformatf("%s rawB n%0d", tag, j),  int'(qB[nB+j]), vecs[k].eB[j]);
      end
    end
  endtask

  initial begin
    int lat, nA, nB, pA, pB, c0, rel, d1, d2, stall_err, hold_err, pushes_in_full;

    mk(0, 256, 256, 256, 256,   128, 128, 128, 128, 128, 128, 128, 128,
       512, 512, 512, 512);
    mk(1, 256, 512, -256, 0,    256, 256, 256, 256, -256, 0, 0, 0,
       512, 0, 512, -256);
    mk(2, 32767, 32767, 32767, 32767,
       32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
       32767, 32767, 32767, 32767);
    mk(3, -32768, -32768, -32768, -32768,
       32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
       0, 0, -32768, -32768);
    mk(4, 1, 0, 0, 0,           -1, 0, 0, 0, 300, 0, 0, 0,
       0, 1, -1, 1);
    mk(5, 100, -200, 300, -400, 256, 256, 256, 256, 512, 0, 0, -256,
       0, 600, -200, 600);

    rst = 1'b1; start = 1'b0; empty = 1'b0; full = 1'b0;
    load_vec(0);
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busyA), 0);
    chk("rst done", int'(doneA), 0);
    chk("rst rd_en", int'(rdA), 0);
    chk("rst wr_en", int'(wrA), 0);
    chk("rst addr", int'(addrA), 0);
    chk("rst data", int'(odA), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      load_vec(k);
      nA = qA.size(); nB = qB.size(); pA = ptrA; pB = ptrB;
      run_inf(lat);
      chk($sformatf("v%0d latency", k), lat, N + M*(N+2) + 1);
      chk($sformatf("v%0d doneB", k), int'(doneB), 1);
      @(negedge clk);
      chk($sformatf("v%0d busy after done", k), int'(busyA), 0);
      chk($sformatf("v%0d done pulse width", k), int'(doneA), 0);
      chk($sformatf("v%0d popsA", k), ptrA - pA, N);
      chk($sformatf("v%0d popsB", k), ptrB - pB, N);
      check_results($sformatf("v%0d", k), k, nA, nB);
    end

    // Input FIFO empty for 5 cycles mid-LOAD, output FIFO full for 7 cycles in first WRITE.
    load_vec(0);
    nA = qA.size(); nB = qB.size(); pA = ptrA;
    stall_err = 0; hold_err = 0; pushes_in_full = -1; lat = -1;
    @(negedge clk);
    c0 = cyc;
    for (int t = 0; t < 80; t++) begin
      rel   = cyc - c0;
      start = (rel == 0);
      empty = (rel >= 3 && rel <= 7);
      full  = (rel <= 21);
      #1;
      if (empty && (rdA || rdB)) stall_err++;
      if (rel >= 15 && rel <= 21) begin
        if (wrA || wrB) stall_err++;
        if (odA !== 16'd512) hold_err++;
      end
      if (rel == 21) pushes_in_full = qA.size() - nA;
      if (doneA) begin
        lat = rel;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; empty = 1'b0; full = 1'b0;
    chk("stall no strobes", stall_err, 0);
    chk("stall data held", hold_err, 0);
    chk("stall no push while full", pushes_in_full, 0);
    chk("stall latency", lat, N + M*(N+2) + 1 + 12);
    chk("stall pops", ptrA - pA, N);
    check_results("stall", 0, nA, nB);

    // layer_start held high: back-to-back inferences, no queued extra work.
    repeat (2) @(negedge clk);
    load_vec(0);
    nA = qA.size(); nB = qB.size(); pA = ptrA;
    d1 = -1; d2 = -1;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (doneA) begin
        if (d1 < 0) d1 = cyc - c0;
        else begin
          d2 = cyc - c0;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b first latency", d1, N + M*(N+2) + 1);
    chk("b2b done spacing", d2 - d1, N + M*(N+2) + 2);
    chk("b2b pushes", qA.size() - nA, 2*M);
    chk("b2b pops", ptrA - pA, 2*N);
    chk("b2b idle after", int'(busyA), 0);
    if (qA.size() >= nA + 2*M)
      for (int j = 0; j < 2*M; j++)
        chk($sformatf("b2b result %0d", j), int'(qA[nA+j]), 512);

    // Reset during COMPUTE of neuron 1: outputs clear at once, nothing more is pushed.
    load_vec(1);
    nA = qA.size();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((cyc - c0) < 12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst data", int'(odA), 0);
    chk("midrst busy", int'(busyA), 0);
    chk("midrst wr_en", int'(wrA), 0);
    chk("midrst addr", int'(addrA), 0);
    chk("midrst pushed before", qA.size() - nA, 1);
    if (qA.size() > nA) chk("midrst neuron0", int'(qA[nA]), 512);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst no late push", qA.size() - nA, 1);
    load_vec(0);
    nA = qA.size(); nB = qB.size();
    run_inf(lat);
    chk("post-rst latency", lat, N + M*(N+2) + 1);
    @(negedge clk);
    check_results("post-rst", 0, nA, nB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
